// File: rtl/trdb_pkg.sv
// rtl/trdb_pkg.sv - shared types for the trace activation controller
package trdb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FLUSH  = 2'd2,
        FINAL  = 2'd3
    } trdb_ctrl_state_e;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        SW    = 2'd1,
        TRIG  = 2'd2,
        DEACT = 2'd3
    } trdb_stop_cause_e;

endpackage

// File: rtl/trdb_trace_ctrl_if.sv
// rtl/trdb_trace_ctrl_if.sv - drain/final-packet handshake between controller and packet emitter
interface trdb_trace_ctrl_if;
    logic pkt_busy;
    logic final_pkt_req;
    logic final_pkt_ack;

    modport master (
        input  pkt_busy,
        input  final_pkt_ack,
        output final_pkt_req
    );

    modport slave (
        output pkt_busy,
        output final_pkt_ack,
        input  final_pkt_req
    );
endinterface

// File: rtl/trdb_drain_timer.sv
// rtl/trdb_drain_timer.sv - saturating FLUSH-cycle counter with clear, enable and done flag
module trdb_drain_timer #(
    parameter int unsigned DRAIN_TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic done_o
);

    localparam int unsigned CNT_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DRAIN_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Done in the cycle whose increment brings the count to DRAIN_TIMEOUT.
    assign done_o = en_i && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/trdb_trace_ctrl.sv
// rtl/trdb_trace_ctrl.sv - trace on/off sequencing with drain and final packet handshake
// Optional: TRDB_TRIGGER_START_EN makes a trigger-on pulse required to arm tracing.
module trdb_trace_ctrl
    import trdb_pkg::*;
#(
    parameter int unsigned DRAIN_TIMEOUT = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    trace_enable_reg_i,
    input  logic                    trigger_trace_on_i,
    input  logic                    trigger_trace_off_i,
    input  logic                    trace_req_deactivate_i,
    trdb_trace_ctrl_if.master       emit_if,
    output logic                    trace_enable_o,
    output logic                    trace_active_o,
    output logic                    reg_clr_enable_o,
    output logic [1:0]              stop_cause_o,
    output logic                    timeout_o
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_ACTIVE = ACTIVE;
    localparam logic [1:0] ST_FLUSH  = FLUSH;
    localparam logic [1:0] ST_FINAL  = FINAL;

    logic [1:0]       state_q, state_d;
    trdb_stop_cause_e cause_q, cause_d;
    logic             timeout_q, timeout_d;
    logic             reg_clr_q, reg_clr_d;
    logic             trace_enable_q, trace_active_q, final_req_q;
    logic             start_cond;
    logic             flush_exit;
    logic             drain_done;

`ifdef TRDB_TRIGGER_START_EN
    assign start_cond = trace_enable_reg_i && trigger_trace_on_i;
`else
    logic unused_trigger_on;
    assign unused_trigger_on = trigger_trace_on_i;
    assign start_cond        = trace_enable_reg_i;
`endif

    trdb_drain_timer #(
        .DRAIN_TIMEOUT (DRAIN_TIMEOUT)
    ) u_drain_timer (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  ((state_q != ST_FLUSH) || flush_exit),
        .en_i   (state_q == ST_FLUSH),
        .done_o (drain_done)
    );

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        timeout_d  = timeout_q;
        reg_clr_d  = 1'b0;
        flush_exit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // The clear pulse cycle still sees the stale enable bit, so it cannot restart.
                if (start_cond && !trigger_trace_off_i && !reg_clr_q) begin
                    state_d   = ST_ACTIVE;
                    timeout_d = 1'b0;
                end
            end
            ST_ACTIVE: begin
                if (!trace_enable_reg_i) begin
                    state_d = ST_FLUSH;
                    cause_d = SW;
                end else if (trigger_trace_off_i) begin
                    state_d = ST_FLUSH;
                    cause_d = TRIG;
                end else if (trace_req_deactivate_i) begin
                    state_d = ST_FLUSH;
                    cause_d = DEACT;
                end
            end
            ST_FLUSH: begin
                if (!emit_if.pkt_busy) begin
                    flush_exit = 1'b1;
                end else if (drain_done) begin
                    flush_exit = 1'b1;
                    timeout_d  = 1'b1;
                end
                if (flush_exit) begin
                    state_d = ST_FINAL;
                end
            end
            ST_FINAL: begin
                if (emit_if.final_pkt_ack) begin
                    state_d   = ST_IDLE;
                    reg_clr_d = (cause_q != SW);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= ST_IDLE;
            cause_q        <= NONE;
            timeout_q      <= 1'b0;
            reg_clr_q      <= 1'b0;
            trace_enable_q <= 1'b0;
            trace_active_q <= 1'b0;
            final_req_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cause_q        <= cause_d;
            timeout_q      <= timeout_d;
            reg_clr_q      <= reg_clr_d;
            trace_enable_q <= (state_d == ST_ACTIVE);
            trace_active_q <= (state_d != ST_IDLE);
            final_req_q    <= (state_d == ST_FINAL);
        end
    end

    assign trace_enable_o        = trace_enable_q;
    assign trace_active_o        = trace_active_q;
    assign emit_if.final_pkt_req = final_req_q;
    assign reg_clr_enable_o      = reg_clr_q;
    assign stop_cause_o          = cause_q;
    assign timeout_o             = timeout_q;

endmodule

// File: tb/tb_trdb_trace_ctrl.sv
// tb/tb_trdb_trace_ctrl.sv - directed self-checking bench for trdb_trace_ctrl
module tb_trdb_trace_ctrl;

    logic       clk;
    logic       rst_n;
    logic       en_reg;
    logic       trig_on;
    logic       trig_off;
    logic       deact;
    logic       trace_en;
    logic       trace_act;
    logic       reg_clr;
    logic [1:0] cause;
    logic       tmo;

    int n_checks = 0;
    int n_pass   = 0;

    trdb_trace_ctrl_if emit ();

    trdb_trace_ctrl #(
        .DRAIN_TIMEOUT (5)
    ) dut (
        .clk_i                  (clk),
        .rst_ni                 (rst_n),
        .trace_enable_reg_i     (en_reg),
        .trigger_trace_on_i     (trig_on),
        .trigger_trace_off_i    (trig_off),
        .trace_req_deactivate_i (deact),
        .emit_if                (emit),
        .trace_enable_o         (trace_en),
        .trace_active_o         (trace_act),
        .reg_clr_enable_o       (reg_clr),
        .stop_cause_o           (cause),
        .timeout_o              (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {trace_enable, trace_active, final_req, reg_clr, stop_cause[1:0], timeout}
    function automatic logic [6:0] outs();
        return {trace_en, trace_act, emit.final_pkt_req, reg_clr, cause, tmo};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b, expected %b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic arm();
        en_reg = 1'b1;
`ifdef TRDB_TRIGGER_START_EN
        trig_on = 1'b1;
        step();
        trig_on = 1'b0;
`else
        step();
`endif
    endtask

    task automatic ack_final();
        emit.final_pkt_ack = 1'b1;
        step();
        emit.final_pkt_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int early;
        rst_n = 1'b0; en_reg = 1'b0; trig_on = 1'b0; trig_off = 1'b0; deact = 1'b0;
        emit.pkt_busy = 1'b0; emit.final_pkt_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outs", 32'(outs()), 32'b0000000);
        rst_n = 1'b1;
        step();
        check_eq("idle_after_reset", 32'(outs()), 32'b0000000);

        // Software start and stop with nothing in flight
        arm();
        check_eq("sw_active", 32'(outs()), 32'b1100000);
        en_reg = 1'b0;
        step();
        check_eq("sw_flush", 32'(outs()), 32'b0100010);
        step();
        check_eq("sw_final", 32'(outs()), 32'b0110010);
        ack_final();
        check_eq("sw_idle_no_clr", 32'(outs()), 32'b0000010);

        // On and off together in IDLE: off wins
        en_reg = 1'b1; trig_on = 1'b1; trig_off = 1'b1;
        step();
        trig_on = 1'b0; trig_off = 1'b0;
        check_eq("idle_on_off_stays", 32'(outs()), 32'b0000010);
        arm();
        check_eq("rearm_active", 32'(outs()), 32'b1100010);
        trig_on = 1'b1;
        step();
        trig_on = 1'b0;
        check_eq("active_on_ignored", 32'(outs()), 32'b1100010);

        // Trigger stop, busy for 5 cycles; drop coincides with the timeout boundary
        trig_off = 1'b1; emit.pkt_busy = 1'b1;
        step();
        trig_off = 1'b0;
        check_eq("trig_flush_1", 32'(outs()), 32'b0100100);
        for (int i = 2; i <= 5; i++) begin
            if (i == 3) begin
                deact = 1'b1; en_reg = 1'b0;
            end
            step();
            deact = 1'b0; en_reg = 1'b1;
            if (i == 5) emit.pkt_busy = 1'b0;
            check_eq($sformatf("trig_flush_%0d", i), 32'(outs()), 32'b0100100);
        end
        step();
        check_eq("trig_final_no_timeout", 32'(outs()), 32'b0110100);
        step();
        check_eq("trig_final_hold", 32'(outs()), 32'b0110100);
        ack_final();
        check_eq("trig_idle_clr_pulse", 32'(outs()), 32'b0001100);
        step();
        check_eq("trig_clr_one_cycle_no_restart", 32'(outs()), 32'b0000100);
        en_reg = 1'b0;

        // Drain timeout with busy stuck high
        arm();
        check_eq("tmo_active", 32'(outs()), 32'b1100100);
        en_reg = 1'b0; emit.pkt_busy = 1'b1;
        step();
        check_eq("tmo_flush_1", 32'(outs()), 32'b0100010);
        for (int i = 2; i <= 5; i++) begin
            step();
            check_eq($sformatf("tmo_flush_%0d", i), 32'(outs()), 32'b0100010);
        end
        step();
        check_eq("tmo_final", 32'(outs()), 32'b0110011);
        ack_final();
        emit.pkt_busy = 1'b0;
        check_eq("tmo_idle_sticky", 32'(outs()), 32'b0000011);
        emit.final_pkt_ack = 1'b1;
        step();
        emit.final_pkt_ack = 1'b0;
        check_eq("idle_ack_ignored", 32'(outs()), 32'b0000011);
        arm();
        check_eq("tmo_cleared_on_activate", 32'(outs()), 32'b1100010);

        // Coinciding stop causes
        en_reg = 1'b0; deact = 1'b1;
        step();
        deact = 1'b0;
        check_eq("sw_beats_deact", 32'(outs()), 32'b0100010);
        step();
        ack_final();
        check_eq("sw_deact_idle", 32'(outs()), 32'b0000010);
        arm();
        trig_off = 1'b1; deact = 1'b1;
        step();
        trig_off = 1'b0; deact = 1'b0;
        check_eq("trig_beats_deact", 32'(outs()), 32'b0100100);
        step();
        ack_final();
        check_eq("trig_deact_idle_clr", 32'(outs()), 32'b0001100);
        step();
        en_reg = 1'b0;
        arm();
        deact = 1'b1;
        step();
        deact = 1'b0;
        check_eq("deact_flush", 32'(outs()), 32'b0100110);
        step();
        ack_final();
        check_eq("deact_idle_clr", 32'(outs()), 32'b0001110);
        step();
        en_reg = 1'b0;

`ifdef TRDB_TRIGGER_START_EN
        en_reg = 1'b1;
        early = 0;
        repeat (10) begin
            step();
            if (trace_en) early++;
        end
        check_eq("no_start_without_trigger", 32'(early), 32'd0);
        trig_on = 1'b1;
        step();
        trig_on = 1'b0;
        check_eq("trigger_starts", 32'(outs()), 32'b1100110);
`else
        early = 0;
        trig_on = 1'b1;
        step();
        trig_on = 1'b0;
        if (trace_en) early++;
        check_eq("trigger_alone_no_start", 32'(early), 32'd0);
        en_reg = 1'b1;
        step();
        check_eq("enable_starts", 32'(outs()), 32'b1100110);
`endif

        // Reset while waiting for the final packet ack
        en_reg = 1'b0;
        step();
        step();
        check_eq("pre_reset_final", 32'(outs()), 32'b0110010);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("async_reset_outs", 32'(outs()), 32'b0000000);
        step();
        rst_n = 1'b1;
        step();
        check_eq("post_reset_idle", 32'(outs()), 32'b0000000);
        step();
        check_eq("post_reset_no_clr", 32'(outs()), 32'b0000000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
